// File: rtl/match_collector.sv
// Collects per-frame correspondence pairs into a first-word-fall-through buffer and drains them downstream.
// Optional build macro MATCH_COLLECTOR_DEPTH_FILTER_EN drops pairs carrying a zero depth sample.
module match_collector #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_start,
  input  logic             i_frame_end,
  input  logic             i_valid,
  input  logic [9:0]       i_src_coor_x,
  input  logic [9:0]       i_src_coor_y,
  input  logic [9:0]       i_dst_coor_x,
  input  logic [9:0]       i_dst_coor_y,
  input  logic [15:0]      i_src_depth,
  input  logic [15:0]      i_dst_depth,
  output logic [71:0]      o_pair,
  output logic             o_pair_valid,
  input  logic             i_pair_ready,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned PAIR_W = 72;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [PAIR_W-1:0]   mem_q [DEPTH];

  logic [PAIR_W-1:0]   wr_pair;
  logic [AW-1:0]       wr_idx;
  logic                empty, full;
  logic                depth_ok, wr_req, wr_en, drop, pop;

  // Buffer status and write/pop qualification, all from cycle-start pointers
  always_comb begin
    wr_pair  = {i_src_coor_x, i_src_coor_y, i_src_depth,
                i_dst_coor_x, i_dst_coor_y, i_dst_depth};
    empty    = (rd_ptr_q == wr_ptr_q);
    full     = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
               (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
`ifdef MATCH_COLLECTOR_DEPTH_FILTER_EN
    depth_ok = (i_src_depth != 16'd0) && (i_dst_depth != 16'd0);
`else
    depth_ok = 1'b1;
`endif
    wr_req   = i_valid && depth_ok && (i_frame_start || (state_q == ST_COLLECT));
    // A frame start flushes first, so the buffer cannot be full for its own write
    wr_en    = wr_req && (i_frame_start || !full);
    drop     = wr_req && !i_frame_start && full;
    pop      = !empty && i_pair_ready && !i_frame_start;
  end

  // Pointer, counter and overflow next-state
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_idx     = wr_ptr_q[AW-1:0];
    count_d    = count_q;
    overflow_d = overflow_q;
    if (i_frame_start) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = PW'(wr_en);
      wr_idx     = '0;
      count_d    = CNT_W'(wr_en);
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      if (wr_en && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Pair storage carries no reset
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_pair;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_frame_start) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (i_frame_end) state_d = ST_DRAIN;
        ST_DRAIN:   if (empty) state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_busy       = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
    o_frame_done = (state_q == ST_DRAIN) && empty;
  end

  assign o_pair       = mem_q[rd_ptr_q[AW-1:0]];
  assign o_pair_valid = !empty;
  assign o_count      = count_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_match_collector.sv
// Scoreboard bench for match_collector: a queue-based frame model predicts buffer contents and status.
module tb_match_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam int CNT_SAT = 7;
  localparam int S_IDLE = 0, S_COLLECT = 1, S_DRAIN = 2;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_frame_start, i_frame_end, i_valid, i_pair_ready;
  logic [9:0]       i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y;
  logic [15:0]      i_src_depth, i_dst_depth;
  logic [71:0]      o_pair;
  logic             o_pair_valid, o_overflow, o_frame_done, o_busy;
  logic [CNT_W-1:0] o_count;

  match_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_frame_start(i_frame_start), .i_frame_end(i_frame_end), .i_valid(i_valid),
    .i_src_coor_x(i_src_coor_x), .i_src_coor_y(i_src_coor_y),
    .i_dst_coor_x(i_dst_coor_x), .i_dst_coor_y(i_dst_coor_y),
    .i_src_depth(i_src_depth), .i_dst_depth(i_dst_depth),
    .o_pair(o_pair), .o_pair_valid(o_pair_valid), .i_pair_ready(i_pair_ready),
    .o_count(o_count), .o_overflow(o_overflow),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          failures = 0;
  logic [71:0] sb[$];
  int          cnt_m = 0;
  bit          ovf_m = 1'b0;
  int          st_m = S_IDLE;
  bit          stall_q = 1'b0;
  logic [71:0] stall_pair;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [71:0] rnd_pair(input bit allow_zero);
    logic [15:0] sd, dd;
    sd = (allow_zero && $urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    dd = (allow_zero && $urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    return {10'($urandom), 10'($urandom), sd, 10'($urandom), 10'($urandom), dd};
  endfunction

  function automatic bit depth_pass(input logic [71:0] p);
`ifdef MATCH_COLLECTOR_DEPTH_FILTER_EN
    return (p[51:36] != 16'd0) && (p[15:0] != 16'd0);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: compare the head pair whenever the DUT presents one, retire it on handshake
  always @(negedge i_clk) begin
    if (i_rst) begin
      stall_q = 1'b0;
    end else begin
      if (o_pair_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_pair", o_pair_valid, 1'b0);
        end else begin
          chk("pair_data", o_pair, sb[0]);
          if (i_pair_ready && !i_frame_start) void'(sb.pop_front());
        end
        if (stall_q) chk("stall_stable", o_pair, stall_pair);
      end
      stall_q    = o_pair_valid && !i_pair_ready && !i_frame_start;
      stall_pair = o_pair;
    end
  end

  // One clock of stimulus, then advance the frame model and check status outputs
  task automatic cycle(input bit fs, input bit fe, input bit v, input bit rdy, input logic [71:0] p);
    int occ0;
    bit honour;
    i_frame_start = fs;
    i_frame_end   = fe;
    i_valid       = v;
    i_pair_ready  = rdy;
    i_src_coor_x  = p[71:62];
    i_src_coor_y  = p[61:52];
    i_src_depth   = p[51:36];
    i_dst_coor_x  = p[35:26];
    i_dst_coor_y  = p[25:16];
    i_dst_depth   = p[15:0];
    occ0 = sb.size();
    @(posedge i_clk);
    #1;
    if (fs) begin
      sb.delete();
      cnt_m = 0;
      ovf_m = 1'b0;
    end
    honour = v && (fs || st_m == S_COLLECT);
    if (honour && depth_pass(p)) begin
      if (fs || occ0 < int'(DEPTH)) begin
        sb.push_back(p);
        if (cnt_m < CNT_SAT) cnt_m++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (fs) st_m = S_COLLECT;
    else if (st_m == S_COLLECT && fe) st_m = S_DRAIN;
    else if (st_m == S_DRAIN && occ0 == 0) st_m = S_IDLE;
    chk("pair_valid", o_pair_valid, sb.size() != 0);
    chk("count", o_count, cnt_m);
    chk("overflow", o_overflow, ovf_m);
    chk("busy", o_busy, st_m != S_IDLE);
    chk("frame_done", o_frame_done, st_m == S_DRAIN && sb.size() == 0);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 30 && st_m != S_IDLE; i++) cycle(0, 0, 0, 1, '0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, '0);
    chk({nm, "_idle"}, o_busy, 1'b0);
    chk({nm, "_no_loss"}, 72'(sb.size()), 72'd0);
  endtask

  logic [71:0] pa, pb;
  int          issued;

  initial begin
    i_rst = 1'b1;
    i_frame_start = 0; i_frame_end = 0; i_valid = 0; i_pair_ready = 0;
    i_src_coor_x = '0; i_src_coor_y = '0; i_dst_coor_x = '0; i_dst_coor_y = '0;
    i_src_depth = '0; i_dst_depth = '0;
    #1;
    chk("rst_pair_valid", o_pair_valid, 1'b0);
    chk("rst_count", o_count, 0);
    chk("rst_overflow", o_overflow, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_frame_done", o_frame_done, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Basic frame: three pairs with a consumer always ready
    cycle(1, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, rnd_pair(0));
    cycle(0, 1, 0, 1, '0);
    chk("basic_count", o_count, 3);
    drain("basic");

    // Overflow: consumer stalled, six pairs into a four-entry buffer
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, rnd_pair(0));
    cycle(0, 1, 0, 0, '0);
    chk("ovf_count", o_count, 4);
    chk("ovf_flag", o_overflow, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, '0);
    drain("ovf");

    // Depth filter: a zero-depth pair then a valid one
    pa = rnd_pair(0); pa[51:36] = 16'd0;
    pb = rnd_pair(0); pb[51:36] = 16'd500; pb[15:0] = 16'd600;
    cycle(1, 0, 1, 0, pa);
    cycle(0, 0, 1, 0, pb);
    cycle(0, 1, 0, 0, '0);
`ifdef MATCH_COLLECTOR_DEPTH_FILTER_EN
    chk("filter_count", o_count, 1);
`else
    chk("filter_count", o_count, 2);
`endif
    drain("filter");

    // Restart during drain with two pending entries and a same-cycle write
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, rnd_pair(0));
    cycle(0, 0, 1, 0, rnd_pair(0));
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(1, 0, 1, 1, rnd_pair(0));
    chk("restart_count", o_count, 1);
    chk("restart_no_done", o_frame_done, 1'b0);
    cycle(0, 1, 0, 1, '0);
    drain("restart");

    // Async reset mid-collect, then a stray pair before the next frame start
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, rnd_pair(0));
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_pair_valid", o_pair_valid, 1'b0);
    chk("arst_count", o_count, 0);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_overflow", o_overflow, 1'b0);
    sb.delete(); cnt_m = 0; ovf_m = 1'b0; st_m = S_IDLE;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    cycle(0, 0, 1, 1, rnd_pair(0));
    cycle(0, 0, 1, 1, rnd_pair(0));
    chk("post_rst_ignored", o_count, 0);

    // Stall stability: 100 pairs against a randomly stalling consumer
    cycle(1, 0, 0, 1, '0);
    issued = 0;
    while (issued < 100) begin
      if ($urandom_range(0, 4) != 0) begin
        cycle(0, 0, 1, 1'($urandom_range(0, 1)), rnd_pair(1));
        issued++;
      end else begin
        cycle(0, 0, 0, 1'($urandom_range(0, 1)), '0);
      end
    end
    cycle(0, 1, 0, 1'($urandom_range(0, 1)), '0);
    drain("stall");

    // Frame-level random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rnd_pair(1));
    end
    cycle(0, 1, 0, 1, '0);
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_collector.md
MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 Parameter DEPTH, default 64, meaning pair-buffer entries; SHALL be a power of two, 4..512.
REQ-002 Parameter CNT_W, default 10, meaning width of the per-frame accepted-pair counter.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous assert, active-high.
REQ-005 i_frame_start  input  1  one-cycle pulse marking the start of a match frame.
REQ-006 i_frame_end  input  1  one-cycle pulse marking the end of a match frame.
REQ-007 i_valid  input  1  one correspondence present this cycle; there is no back-pressure toward the source.
REQ-008 i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y  input  10 each  pixel coordinates.
REQ-009 i_src_depth, i_dst_depth  input  16 each  depth samples; 0 means invalid.
REQ-010 o_pair  output  72  head entry, packed {src_x, src_y, src_depth, dst_x, dst_y, dst_depth}, MSB first.
REQ-011 o_pair_valid  output  1  buffer non-empty; o_pair is meaningful.
REQ-012 i_pair_ready  input  1  downstream consumer accepts the head entry.
REQ-013 o_count  output  CNT_W  pairs written this frame, saturating.
REQ-014 o_overflow  output  1  sticky per frame; at least one pair was dropped because the buffer was full.
REQ-015 o_frame_done  output  1  one-cycle pulse: the frame has ended and the buffer has drained.
REQ-016 o_busy  output  1  high when the state is COLLECT or DRAIN.

Function
REQ-017 States: IDLE, COLLECT, DRAIN; reset state IDLE.
REQ-018 i_frame_start in any state: flush the buffer, clear o_count and o_overflow, enter COLLECT next cycle.
REQ-019 i_valid is honoured only in COLLECT, or in the same cycle as i_frame_start; otherwise it is ignored.
REQ-020 i_valid together with i_frame_start: flush first, then write the pair, so o_count=1 on the next cycle.
REQ-021 COLLECT + i_frame_end (and no i_frame_start): enter DRAIN; an i_valid pair in the same cycle is still written.
REQ-022 i_frame_end outside COLLECT: ignored.
REQ-023 DRAIN with the buffer empty: pulse o_frame_done for one cycle, then enter IDLE. If the buffer is already empty on DRAIN entry, the pulse comes on the first DRAIN cycle.
REQ-024 Buffer is first-word-fall-through: o_pair_valid=!empty; o_pair=head entry, combinationally from storage, with no extra latency.
REQ-025 Read handshake: the head pops when o_pair_valid && i_pair_ready. o_pair SHALL hold stable while o_pair_valid && !i_pair_ready.
REQ-026 Write to pop latency: a pair written in cycle N SHALL show on o_pair_valid in cycle N+1.
REQ-027 Full condition is evaluated at cycle start. A write when full is dropped and sets o_overflow, even if a pop occurs in the same cycle. There is no bypass.
REQ-028 Simultaneous write and pop, not full: occupancy is unchanged.
REQ-029 Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full: pointers differ only in the MSB. Empty: pointers are equal.
REQ-030 o_count increments on each successful write and saturates at 2^CNT_W-1; dropped or filtered pairs do not count.
REQ-031 Flush on i_frame_start overrides a same-cycle pop; the popped data is discarded.

Reset
REQ-032 Asserting i_rst immediately forces: state IDLE, pointers 0, o_pair_valid=0, o_count=0, o_overflow=0, o_frame_done=0, o_busy=0. o_pair is don't-care.
REQ-033 Reset mid-frame discards all buffered pairs. After release, the block ignores i_valid until the next i_frame_start.
REQ-034 Storage contents are not reset.

Configuration
REQ-035 Macro MATCH_COLLECTOR_DEPTH_FILTER_EN is a compile-time option.
- Defined: a pair with i_src_depth==0 or i_dst_depth==0 is discarded. It is not written, not counted, and does not affect o_overflow.
- Undefined: all honoured pairs are written regardless of depth.

Verification
REQ-036 Basic frame: frame_start, 3 valid pairs, frame_end, i_pair_ready=1. Response: 3 pairs out in order, o_count=3, one o_frame_done pulse after the 3rd pop, state IDLE.
REQ-037 Overflow: DEPTH=4, i_pair_ready=0, 6 pairs. Response: o_count=4, o_overflow=1; the first 4 pairs are read back after ready rises.
REQ-038 Stall stability: random i_pair_ready. Response: o_pair is unchanged while valid&&!ready; no loss or duplication across 100 pairs.
REQ-039 Filter: with the macro defined, pair src_depth=0 then pair depths 500/600. Response: o_count=1, only the second pair appears. Without the macro: o_count=2.
REQ-040 Restart: frame_start during DRAIN with 2 entries pending, plus i_valid in the same cycle. Response: the pending entries are discarded, o_count=1, no o_frame_done for the aborted frame.
REQ-041 Async reset: assert i_rst mid-COLLECT with 5 entries buffered. Response: o_pair_valid=0 and o_count=0 with no clock edge; a post-release i_valid before frame_start is ignored.
